// File: rtl/hex_digit_scanner.sv
// Time-multiplexed hex digit scanner for a 7-segment display with a shared decoder.
// Anode dead-time per slot; the displayed value is double-buffered and swapped only at frame wrap.
module hex_digit_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int DEAD_CYCLES  = 500,
    parameter bit AN_ACTIVE_LO = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [4*NUM_DIGITS-1:0]       value,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    input  logic                          load,
    output logic [3:0]                    digit_hex,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = (DEAD_CYCLES > 0) ? CW'(DEAD_CYCLES - 1) : '0;
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_ON   = 1'b1
    } state_t;

    localparam state_t SLOT_START = (DEAD_CYCLES > 0) ? ST_DEAD : ST_ON;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [CW-1:0]           cnt_r;
    logic [IW-1:0]           idx_r;
    logic [4*NUM_DIGITS-1:0] pend_value_r;
    logic [NUM_DIGITS-1:0]   pend_mask_r;
    logic                    pend_valid_r;
    logic [4*NUM_DIGITS-1:0] shadow_value_r;
    logic [NUM_DIGITS-1:0]   shadow_mask_r;
    logic                    frame_done_r;
    logic                    slot_end_s;
    logic                    wrap_s;
    logic [NUM_DIGITS-1:0]   an_act_s;

    assign slot_end_s = (cnt_r == CNT_LAST);
    assign wrap_s     = slot_end_s && (idx_r == IDX_LAST);

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= SLOT_START;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Slot next-state: dark phase at slot start, lit once the dead time has elapsed.
    always_comb begin
        state_next_s = state_r;
        if (slot_end_s) begin
            state_next_s = SLOT_START;
        end else begin
            case (state_r)
                ST_DEAD: begin
                    if (cnt_r == DEAD_LAST) begin
                        state_next_s = ST_ON;
                    end else begin
                        state_next_s = ST_DEAD;
                    end
                end
                ST_ON:   state_next_s = ST_ON;
                default: state_next_s = SLOT_START;
            endcase
        end
    end

    // Slot cycle counter, digit index and frame-wrap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r        <= '0;
            idx_r        <= '0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= wrap_s;
            if (slot_end_s) begin
                cnt_r <= '0;
                if (idx_r == IDX_LAST) begin
                    idx_r <= '0;
                end else begin
                    idx_r <= idx_r + IW'(1);
                end
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    // Double buffer: a load arriving on the wrap edge goes straight to the shadow copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_value_r   <= '0;
            pend_mask_r    <= '0;
            pend_valid_r   <= 1'b0;
            shadow_value_r <= '0;
            shadow_mask_r  <= '0;
        end else begin
            if (wrap_s) begin
                pend_valid_r <= 1'b0;
                if (load) begin
                    shadow_value_r <= value;
                    shadow_mask_r  <= blank_mask;
                end else if (pend_valid_r) begin
                    shadow_value_r <= pend_value_r;
                    shadow_mask_r  <= pend_mask_r;
                end
            end else if (load) begin
                pend_value_r <= value;
                pend_mask_r  <= blank_mask;
                pend_valid_r <= 1'b1;
            end
        end
    end

    // Anode decode from registered state only.
    always_comb begin
        an_act_s = '0;
        if ((state_r == ST_ON) && !shadow_mask_r[idx_r]) begin
            an_act_s[idx_r] = 1'b1;
        end else begin
            an_act_s = '0;
        end
    end

    assign an         = AN_ACTIVE_LO ? ~an_act_s : an_act_s;
    assign digit_hex  = shadow_value_r[{idx_r, 2'b00} +: 4];
    assign digit_idx  = idx_r;
    assign frame_done = frame_done_r;

endmodule
